// File: rtl/gpr_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : gpr_file_mp_if
// Brief    : Decode/writeback bundle for the multi-port register file.
// Revision : 1.0
// ============================================================================
interface gpr_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
) ();
    logic                         clear_req;
    logic                         ready;
    logic [NUM_WR-1:0]            reg_write;
    logic [NUM_WR*ADDR_WIDTH-1:0] num_write;
    logic [NUM_WR*DATA_WIDTH-1:0] data_write;
    logic [NUM_RD*ADDR_WIDTH-1:0] rs;
    // Net so each read port can drive its own slice.
    wire  [NUM_RD*DATA_WIDTH-1:0] rd_data;

    modport master (
        output clear_req, reg_write, num_write, data_write, rs,
        input  ready, rd_data
    );

    modport slave (
        input  clear_req, reg_write, num_write, data_write, rs,
        output ready, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/gpr_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : gpr_file_mp
// Brief    : Parametrised multi-port register file with clear sequencer.
//            Optional macro GPR_BYPASS_EN enables read-after-write forwarding.
// Revision : 1.0
// ============================================================================
module gpr_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1
) (
    input  wire logic        clock,
    input  wire logic        reset,
    gpr_file_mp_if.slave     bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG == 0) || (a != '0);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (bus.clear_req) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                        ready_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // Ascending port loop: the highest enabled port index lands last and wins.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!ready_q) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (bus.reg_write[i] && addr_ok(bus.num_write[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                        mem_q[bus.num_write[i*ADDR_WIDTH +: ADDR_WIDTH]] <=
                            bus.data_write[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    assign bus.ready = ready_q;

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic [DATA_WIDTH-1:0] w_rdata;

        assign w_raddr = bus.rs[j*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_rdata = '0;
            if (ready_q && addr_ok(w_raddr)) begin
                w_rdata = mem_q[w_raddr];
`ifdef GPR_BYPASS_EN
                for (int i = 0; i < NUM_WR; i++) begin
                    if (bus.reg_write[i] && (bus.num_write[i*ADDR_WIDTH +: ADDR_WIDTH] == w_raddr)) begin
                        w_rdata = bus.data_write[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
`endif
            end
        end

        assign bus.rd_data[j*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
    end
endmodule
`default_nettype wire

// File: tb/tb_gpr_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_file_mp
// Brief    : Self-checking bench for gpr_file_mp (2 read, 2 write ports).
// Revision : 1.0
// ============================================================================
module tb_gpr_file_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    gpr_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

    gpr_file_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents, readiness and cycles left in a clear.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_ready = 1'b0;
    int            m_left  = DEPTH;

    task automatic drive_idle();
        bus.reg_write  = '0;
        bus.num_write  = '0;
        bus.data_write = '0;
        bus.rs         = '0;
        bus.clear_req  = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
        bus.reg_write[p]          = 1'b1;
        bus.num_write[p*AW +: AW] = AW'(a);
        bus.data_write[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.rs[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [DW-1:0] exp_rd(input int j);
        int a;
        logic [DW-1:0] v;
        a = int'(bus.rs[j*AW +: AW]);
        if (!m_ready || a == 0) return '0;
        v = m_mem[a];
`ifdef GPR_BYPASS_EN
        for (int i = 0; i < NWR; i++)
            if (bus.reg_write[i] && int'(bus.num_write[i*AW +: AW]) == a)
                v = bus.data_write[i*DW +: DW];
`endif
        return v;
    endfunction

    // Advance the model by one edge using the inputs currently driven, then clock.
    task automatic cycle();
        if (reset) begin
            m_ready = 1'b0;
            m_left  = DEPTH;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
            end
        end else begin
            for (int i = 0; i < NWR; i++)
                if (bus.reg_write[i] && bus.num_write[i*AW +: AW] != '0)
                    m_mem[bus.num_write[i*AW +: AW]] = bus.data_write[i*DW +: DW];
            if (bus.clear_req) begin
                m_ready = 1'b0;
                m_left  = DEPTH;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int n;
        drive_idle();
        reset = 1'b1;
        cycle();
        cycle();
        #2;
        n_cmp++;
        if (bus.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 0", bus.ready);
        end
        reset = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (n != DEPTH) begin
            n_bad++;
            $display("FAIL reset_clear_len: got %0d cycles want %0d", n, DEPTH);
        end
        set_rd(0, 5);
        set_rd(1, 31);
        #2;
        for (int j = 0; j < NRD; j++) begin
            n_cmp++;
            if (bus.rd_data[j*DW +: DW] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_read%0d: got %h want 0", j, bus.rd_data[j*DW +: DW]);
            end
        end
    endtask

    task automatic test_basic();
        drive_idle();
        set_wr(0, 7, 32'hDEADBEEF);
        cycle();
        drive_idle();
        set_rd(0, 7);
        set_rd(1, 0);
        #2;
        n_cmp++;
        if (bus.rd_data[0 +: DW] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL basic_r7: got %h want deadbeef", bus.rd_data[0 +: DW]);
        end
        n_cmp++;
        if (bus.rd_data[DW +: DW] !== 32'h0) begin
            n_bad++;
            $display("FAIL basic_r0: got %h want 0", bus.rd_data[DW +: DW]);
        end
        set_wr(0, 0, 32'h1234);
        cycle();
        drive_idle();
        set_rd(0, 0);
        #2;
        n_cmp++;
        if (bus.rd_data[0 +: DW] !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_reg_write: got %h want 0", bus.rd_data[0 +: DW]);
        end
    endtask

    task automatic test_priority();
        drive_idle();
        set_wr(0, 3, 32'h11);
        set_wr(1, 3, 32'h22);
        cycle();
        drive_idle();
        set_rd(1, 3);
        #2;
        n_cmp++;
        if (bus.rd_data[DW +: DW] !== 32'h22) begin
            n_bad++;
            $display("FAIL wr_priority: got %h want 22", bus.rd_data[DW +: DW]);
        end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] want;
        drive_idle();
        set_wr(0, 9, 32'hA);
        cycle();
        drive_idle();
        set_wr(1, 9, 32'hB);
        set_rd(0, 9);
        #2;
`ifdef GPR_BYPASS_EN
        want = 32'hB;
`else
        want = 32'hA;
`endif
        n_cmp++;
        if (bus.rd_data[0 +: DW] !== want) begin
            n_bad++;
            $display("FAIL raw_same_cycle: got %h want %h", bus.rd_data[0 +: DW], want);
        end
        cycle();
        drive_idle();
        set_rd(0, 9);
        #2;
        n_cmp++;
        if (bus.rd_data[0 +: DW] !== 32'hB) begin
            n_bad++;
            $display("FAIL raw_next_cycle: got %h want b", bus.rd_data[0 +: DW]);
        end
        set_wr(0, 0, 32'hC);
        set_rd(0, 0);
        #2;
        n_cmp++;
        if (bus.rd_data[0 +: DW] !== 32'h0) begin
            n_bad++;
            $display("FAIL raw_r0: got %h want 0", bus.rd_data[0 +: DW]);
        end
        cycle();
        drive_idle();
    endtask

    task automatic test_reclear();
        int n;
        drive_idle();
        set_wr(0, 4, 32'h55);
        cycle();
        drive_idle();
        bus.clear_req = 1'b1;
        cycle();
        bus.clear_req = 1'b0;
        set_wr(1, 4, 32'h77);
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            cycle();
            drive_idle();
            n++;
        end
        n_cmp++;
        if (n != DEPTH) begin
            n_bad++;
            $display("FAIL reclear_len: got %0d cycles want %0d", n, DEPTH);
        end
        set_rd(0, 4);
        #2;
        n_cmp++;
        if (bus.rd_data[0 +: DW] !== 32'h0) begin
            n_bad++;
            $display("FAIL reclear_r4: got %h want 0", bus.rd_data[0 +: DW]);
        end
    endtask

    task automatic test_reset_midclear();
        int n;
        drive_idle();
        bus.clear_req = 1'b1;
        cycle();
        bus.clear_req = 1'b0;
        repeat (10) cycle();
        #2;
        n_cmp++;
        if (bus.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midclear_ready: got %b want 0", bus.ready);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (n != DEPTH) begin
            n_bad++;
            $display("FAIL midclear_restart_len: got %0d cycles want %0d", n, DEPTH);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 500; t++) begin
            drive_idle();
            for (int i = 0; i < NWR; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_wr(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1), $urandom);
            end
            for (int j = 0; j < NRD; j++)
                set_rd(j, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1));
            bus.clear_req = ($urandom_range(0, 149) == 0);
            #2;
            n_cmp++;
            if (bus.ready !== m_ready) begin
                n_bad++;
                $display("FAIL rand_ready t=%0d: got %b want %b", t, bus.ready, m_ready);
            end
            for (int j = 0; j < NRD; j++) begin
                n_cmp++;
                if (bus.rd_data[j*DW +: DW] !== exp_rd(j)) begin
                    n_bad++;
                    $display("FAIL rand_rd%0d t=%0d: got %h want %h", j, t, bus.rd_data[j*DW +: DW], exp_rd(j));
                end
            end
            cycle();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_basic();
        test_priority();
        test_same_cycle();
        test_reclear();
        test_reset_midclear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/gpr_file_mp.md
Name: gpr_file_mp

Overview:
Parametrised multi-port general-purpose register file for the next-generation CPU core. It replaces the fixed 32x32, two-read/one-write register file. Data width, register count, read-port count and write-port count are generalised. It adds a hardware clear sequencer with a ready flag, deterministic write-port priority, and optional read-after-write forwarding. It sits between decode (read addresses) and writeback (write ports).

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 1, number of write ports (>=1)
ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register

Ports:
clock  input  1  rising-edge clock; sole clock
reset  input  1  synchronous, active-high reset
clear_req  input  1  request a full re-clear; honoured only in READY
ready  output  1  1 = file usable; 0 = clear in progress
reg_write  input  NUM_WR  per-port write enable
num_write  input  NUM_WR*ADDR_WIDTH  write addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
data_write  input  NUM_WR*DATA_WIDTH  write data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
rs  input  NUM_RD*ADDR_WIDTH  read addresses; same packing as num_write
rd_data  output  NUM_RD*DATA_WIDTH  read data; same packing as data_write

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- FSM states: CLEAR and READY.
  - reset=1 at a clock edge -> CLEAR; clear counter = 0; ready = 0 (reset value).
  - CLEAR: each cycle writes 0 to entry[counter], then counter += 1.
  - After entry DEPTH-1 is written -> READY. ready=1 from the next cycle. A clear takes exactly DEPTH cycles after reset deasserts.
  - READY with clear_req=1 -> CLEAR with counter = 0. ready drops the next cycle. External writes in that same cycle still commit.
  - reset asserted mid-clear restarts the clear from counter 0.
  - clear_req is ignored in CLEAR.
- Writes:
  - Commit on the rising edge only when ready=1 and reg_write[i]=1.
  - Writes presented while ready=0 are dropped, not queued.
  - If ZERO_REG=1, writes to address 0 are ignored.
  - Same address on several enabled ports in one cycle: the highest port index wins.
- Reads:
  - Combinational, zero latency: rd_data port j = entry[rs port j].
  - If ZERO_REG=1 and the address is 0, the result is always 0.
  - While ready=0, all rd_data read 0, independent of array contents.
  - Without forwarding, a read of an address written in the same cycle returns the old value; the new value is visible from the next cycle.
- Widths: addresses are unsigned. No truncation or extension; data is stored exactly DATA_WIDTH bits.
- Storage: no per-entry reset; the sequencer is the only clearing mechanism. Array contents before the first completed clear are undefined but never visible (ready=0).

Optional Feature:
GPR_BYPASS_EN
- Defined: read-after-write forwarding. If ready=1 and any enabled write port targets rs of read port j (excluding address 0 when ZERO_REG=1), rd_data port j returns that port's data_write in the same cycle. Same highest-index priority as the array write.
- Not defined: no forwarding logic. Reads always reflect the array state from the previous edge.

Test Plan:
1. Reset clear timing, DEPTH=32: assert reset 2 cycles, then release -> ready=0 for exactly 32 cycles, then ready=1; rs=5 and rs=31 read 0.
2. Basic write/read after ready: write 0xDEADBEEF to r7, then read rs0=7, rs1=0 -> next cycle rd0=0xDEADBEEF, rd1=0. A write of 0x1234 to r0 leaves r0 reading 0.
3. Write-port priority, NUM_WR=2: port0 writes r3=0x11, port1 writes r3=0x22 in the same cycle -> r3 reads 0x22.
4. Same-cycle read/write of r9 (old value 0xA, new value 0xB):
   - without GPR_BYPASS_EN -> rd=0xA that cycle, 0xB the next cycle;
   - with GPR_BYPASS_EN -> rd=0xB in the same cycle;
   - writing r0 with bypass on -> rd=0.
5. Re-clear: r4=0x55, pulse clear_req for 1 cycle -> ready=0 for 32 cycles; a write to r4 during the clear is dropped; once ready=1, r4 reads 0.
6. Reset mid-clear: assert reset at clear cycle 10 -> the counter restarts, and ready rises 32 cycles after reset deasserts, not earlier.
